// File: rtl/mux_sel_scheduler_pkg.sv
`default_nettype none
// ------------------------------------------------------------------------
// mux_sel_scheduler_pkg - demux select codes, scheduler states, idx->sel map
// Rev 1.0
// ------------------------------------------------------------------------
package mux_sel_scheduler_pkg;

  localparam logic [2:0] SEL_NONE = 3'd0;
  localparam logic [2:0] SEL_M1   = 3'd1;
  localparam logic [2:0] SEL_M2   = 3'd2;
  localparam logic [2:0] SEL_S1   = 3'd3;
  localparam logic [2:0] SEL_S2   = 3'd4;
  localparam logic [2:0] SEL_S3   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARB  = 2'd1,
    ST_SEND = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Requester index 0..4 maps onto SEL_M1..SEL_S3.
  function automatic logic [2:0] idx_to_sel(input logic [2:0] idx);
    return idx + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_sel_scheduler_rr_arbiter.sv
`default_nettype none
// ------------------------------------------------------------------------
// rr_arbiter_5 - combinational 5-way round-robin pick, search from ptr+1
// Rev 1.0
// ------------------------------------------------------------------------
module rr_arbiter_5 (
  input  logic [4:0] pending,
  input  logic [2:0] ptr,
  output logic [2:0] grant,
  output logic       grant_valid
);

  logic [2:0] cand;

  always_comb begin
    grant       = 3'd0;
    grant_valid = 1'b0;
    cand        = 3'd0;
    for (int k = 1; k <= 5; k++) begin
      cand = 3'((int'(ptr) + k) % 5);
      if (!grant_valid && pending[cand]) begin
        grant       = cand;
        grant_valid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux_sel_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------------
// mux_sel_scheduler - round-robin packet sequencer driving the demux sel
// Rev 1.0
// ------------------------------------------------------------------------
module mux_sel_scheduler
  import mux_sel_scheduler_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int N_REQ   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_len,
  input  logic [7:0]         req_seed,
  input  logic               tready,
  output logic [2:0]         sel,
  output logic [7:0]         tdata,
  output logic               tvalid,
  output logic               tlast,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   abort,
  output logic               busy
);

  localparam int SW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [SW-1:0] STALL_LAST = SW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t             state, state_nxt;
  logic [N_REQ-1:0]   pending, pending_nxt;
  logic [2:0]         ptr, ptr_nxt, gnt, gnt_nxt;
  logic [7:0]         len, len_nxt, seed, seed_nxt, cnt, cnt_nxt;
  logic [SW-1:0]      stall, stall_nxt;
  logic               rearm, rearm_nxt;
  logic [2:0]         sel_nxt;
  logic [7:0]         tdata_nxt;
  logic               tvalid_nxt, tlast_nxt;
  logic [N_REQ-1:0]   done_nxt, abort_nxt;
  logic               finish;
  logic [2:0]         arb_idx;
  logic               arb_valid;

  rr_arbiter_5 u_arb (
    .pending     (pending),
    .ptr         (ptr),
    .grant       (arb_idx),
    .grant_valid (arb_valid)
  );

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending | req;
    ptr_nxt     = ptr;
    gnt_nxt     = gnt;
    len_nxt     = len;
    seed_nxt    = seed;
    cnt_nxt     = cnt;
    stall_nxt   = stall;
    rearm_nxt   = rearm;
    sel_nxt     = sel;
    tdata_nxt   = tdata;
    tvalid_nxt  = tvalid;
    tlast_nxt   = tlast;
    done_nxt    = '0;
    abort_nxt   = '0;
    finish      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_nxt   = arb_idx;
          sel_nxt   = idx_to_sel(arb_idx);
          len_nxt   = req_len[{arb_idx, 3'b000} +: 8];
          seed_nxt  = req_seed;
          cnt_nxt   = 8'd0;
          stall_nxt = '0;
          rearm_nxt = 1'b0;
          state_nxt = ST_ARB;
        end
      end
      ST_ARB: begin
        // The owner's pending bit stays set while granted, so new requests
        // from it are remembered here and restored when the packet ends.
        rearm_nxt  = rearm | req[gnt];
        tdata_nxt  = seed;
        tvalid_nxt = 1'b1;
        tlast_nxt  = (len == 8'd0);
        state_nxt  = ST_SEND;
      end
      ST_SEND: begin
        rearm_nxt = rearm | req[gnt];
        if (tvalid && tready) begin
          stall_nxt = '0;
          if (tlast) begin
            done_nxt[gnt] = 1'b1;
            finish        = 1'b1;
          end else begin
            cnt_nxt   = cnt + 8'd1;
            tdata_nxt = tdata + 8'd1;
            tlast_nxt = ((cnt + 8'd1) == len);
          end
        end else if (TIMEOUT != 0 && stall == STALL_LAST) begin
          abort_nxt[gnt] = 1'b1;
          finish         = 1'b1;
        end else begin
          stall_nxt = stall + 1'b1;
        end
        if (finish) begin
          tvalid_nxt       = 1'b0;
          tlast_nxt        = 1'b0;
          sel_nxt          = SEL_NONE;
          ptr_nxt          = gnt;
          pending_nxt[gnt] = rearm_nxt;
          state_nxt        = ST_GAP;
        end
      end
      ST_GAP: begin
        sel_nxt    = SEL_NONE;
        tvalid_nxt = 1'b0;
        state_nxt  = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      pending <= '0;
      ptr     <= 3'd4;
      gnt     <= 3'd0;
      len     <= 8'd0;
      seed    <= 8'd0;
      cnt     <= 8'd0;
      stall   <= '0;
      rearm   <= 1'b0;
      sel     <= SEL_NONE;
      tdata   <= 8'd0;
      tvalid  <= 1'b0;
      tlast   <= 1'b0;
      done    <= '0;
      abort   <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      ptr     <= ptr_nxt;
      gnt     <= gnt_nxt;
      len     <= len_nxt;
      seed    <= seed_nxt;
      cnt     <= cnt_nxt;
      stall   <= stall_nxt;
      rearm   <= rearm_nxt;
      sel     <= sel_nxt;
      tdata   <= tdata_nxt;
      tvalid  <= tvalid_nxt;
      tlast   <= tlast_nxt;
      done    <= done_nxt;
      abort   <= abort_nxt;
      busy    <= (state_nxt != ST_IDLE);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_sel_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------------
// tb_mux_sel_scheduler - directed and randomized bench with packet-level model
// Rev 1.0
// ------------------------------------------------------------------------
module tb_mux_sel_scheduler;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  req;
  logic [39:0] req_len;
  logic [7:0]  req_seed;
  logic        tready;
  logic [2:0]  sel;
  logic [7:0]  tdata;
  logic        tvalid, tlast, busy;
  logic [4:0]  done, abort;

  mux_sel_scheduler #(.TIMEOUT(TMO), .N_REQ(5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .req_seed(req_seed),
    .tready(tready), .sel(sel), .tdata(tdata), .tvalid(tvalid), .tlast(tlast),
    .done(done), .abort(abort), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_tests++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Packet-level model: pending set, RR pick, packet as a queue of bytes.
  logic [4:0] m_pend;
  int         m_ptr, m_owner, m_stage, m_stall;
  bit         m_rearm;
  logic [7:0] q[$];
  logic [2:0] exp_sel;
  logic [7:0] exp_tdata;
  logic       exp_tvalid, exp_tlast, exp_busy;
  logic [4:0] exp_done, exp_abort;

  task automatic model_step();
    logic [4:0] np;
    bit fin;
    if (!rst_n) begin
      m_pend = '0; m_ptr = 4; m_owner = 0; m_stage = 0; m_stall = 0; m_rearm = 0;
      q.delete();
      exp_sel = 0; exp_tdata = 0; exp_tvalid = 0; exp_tlast = 0;
      exp_done = 0; exp_abort = 0; exp_busy = 0;
      return;
    end
    np = m_pend | req;
    exp_done = 0; exp_abort = 0; fin = 0;
    case (m_stage)
      0: if (m_pend != 0) begin
        for (int k = 1; k <= 5; k++) begin
          if (m_pend[(m_ptr + k) % 5]) begin m_owner = (m_ptr + k) % 5; break; end
        end
        q.delete();
        for (int k = 0; k <= int'(req_len[8*m_owner +: 8]); k++) q.push_back(8'(int'(req_seed) + k));
        exp_sel = 3'(m_owner + 1); m_rearm = 0; m_stall = 0; m_stage = 1;
      end
      1: begin
        m_rearm = m_rearm | req[m_owner];
        exp_tvalid = 1; exp_tdata = q[0]; exp_tlast = (q.size() == 1); m_stage = 2;
      end
      2: begin
        m_rearm = m_rearm | req[m_owner];
        if (tready) begin
          m_stall = 0;
          void'(q.pop_front());
          if (q.size() == 0) begin exp_done[m_owner] = 1'b1; fin = 1; end
          else begin exp_tdata = q[0]; exp_tlast = (q.size() == 1); end
        end else begin
          m_stall++;
          if (TMO != 0 && m_stall >= TMO) begin exp_abort[m_owner] = 1'b1; fin = 1; end
        end
        if (fin) begin
          exp_tvalid = 0; exp_tlast = 0; exp_sel = 0; m_ptr = m_owner;
          np[m_owner] = m_rearm; m_stage = 3;
        end
      end
      default: m_stage = 0;
    endcase
    exp_busy = (m_stage != 0);
    m_pend = np;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Handshake log for directed literal checks.
  logic [7:0] hs_data[$];
  int         hs_sel[$];
  int         hs_last[$];
  int         vcyc, done_cnt, abort_cnt;
  logic [4:0] abort_seen;

  task automatic clear_logs();
    hs_data.delete(); hs_sel.delete(); hs_last.delete();
    vcyc = 0; done_cnt = 0; abort_cnt = 0; abort_seen = 0;
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("sel", int'(sel), int'(exp_sel));
      chk("tvalid", int'(tvalid), int'(exp_tvalid));
      chk("tlast", int'(tlast), int'(exp_tlast));
      chk("done", int'(done), int'(exp_done));
      chk("abort", int'(abort), int'(exp_abort));
      chk("busy", int'(busy), int'(exp_busy));
      if (exp_tvalid) chk("tdata", int'(tdata), int'(exp_tdata));
      if ((done | abort) != 0) chk("onehot_done_abort", $countones(done | abort), 1);
      if (tvalid && tready) begin
        hs_data.push_back(tdata); hs_sel.push_back(int'(sel)); hs_last.push_back(int'(tlast));
      end
      if (tvalid) vcyc++;
      done_cnt  += $countones(done);
      abort_cnt += $countones(abort);
      abort_seen |= abort;
    end
  end

  task automatic cyc(input logic [4:0] r, input logic t);
    req = r; tready = t;
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(5'd0, 1'b1);
    rst_n = 1'b1;
  endtask

  int mode;
  logic [4:0] rq;
  logic tr;

  initial begin
    rst_n = 1'b0; req = 0; tready = 0; req_len = 0; req_seed = 0;
    clear_logs();
    @(posedge clk); #2;
    chk_en = 1'b1;
    cyc(5'd0, 1'b0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_tdata", int'(tdata), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;

    // 1: single packet, 4 beats from 0x10
    clear_logs();
    req_len = 40'd0; req_len[7:0] = 8'd3; req_seed = 8'h10;
    cyc(5'b00001, 1'b1);
    repeat (12) cyc(5'd0, 1'b1);
    chk("t1_beats", hs_data.size(), 4);
    for (int i = 0; i < hs_data.size() && i < 4; i++) begin
      chk("t1_data", int'(hs_data[i]), 16 + i);
      chk("t1_last", hs_last[i], (i == 3) ? 1 : 0);
      chk("t1_sel", hs_sel[i], 1);
    end
    chk("t1_done", done_cnt, 1);

    // 2: backpressure 1,0,0,1,0,1,1
    clear_logs();
    cyc(5'b00001, 1'b0); cyc(5'd0, 1'b0); cyc(5'd0, 1'b0);
    cyc(5'd0, 1'b1); cyc(5'd0, 1'b0); cyc(5'd0, 1'b0); cyc(5'd0, 1'b1);
    cyc(5'd0, 1'b0); cyc(5'd0, 1'b1); cyc(5'd0, 1'b1);
    repeat (6) cyc(5'd0, 1'b1);
    chk("t2_beats", hs_data.size(), 4);
    for (int i = 0; i < hs_data.size() && i < 4; i++) chk("t2_data", int'(hs_data[i]), 16 + i);
    chk("t2_abort", abort_cnt, 0);

    // 3: round-robin order
    do_reset(); clear_logs();
    req_len = 40'd0;
    cyc(5'b11111, 1'b1);
    repeat (30) cyc(5'd0, 1'b1);
    chk("t3a_cnt", hs_sel.size(), 5);
    for (int i = 0; i < hs_sel.size() && i < 5; i++) chk("t3a_sel", hs_sel[i], i + 1);
    clear_logs();
    cyc(5'b10101, 1'b1);
    repeat (20) cyc(5'd0, 1'b1);
    chk("t3b_cnt", hs_sel.size(), 3);
    for (int i = 0; i < hs_sel.size() && i < 3; i++) chk("t3b_sel", hs_sel[i], 2 * i + 1);

    // 4: watchdog on s2
    do_reset(); clear_logs();
    req_len = 40'd0; req_len[31:24] = 8'd5;
    cyc(5'b01000, 1'b0);
    repeat (35) cyc(5'd0, 1'b0);
    chk("t4_valid_cycles", vcyc, 16);
    chk("t4_abort_cnt", abort_cnt, 1);
    chk("t4_abort_bits", int'(abort_seen), 8);
    chk("t4_done", done_cnt, 0);
    chk("t4_busy", int'(busy), 0);

    // 5: reset mid-packet
    do_reset(); clear_logs();
    req_len = 40'd0; req_len[15:8] = 8'd9; req_seed = 8'h20;
    cyc(5'b00010, 1'b1);
    repeat (4) cyc(5'd0, 1'b1);
    rst_n = 1'b0;
    cyc(5'd0, 1'b1);
    chk("t5_sel", int'(sel), 0);
    chk("t5_tvalid", int'(tvalid), 0);
    chk("t5_busy", int'(busy), 0);
    rst_n = 1'b1;
    clear_logs();
    repeat (12) cyc(5'd0, 1'b1);
    chk("t5_no_valid", vcyc, 0);
    chk("t5_no_done", done_cnt, 0);

    // 6: 256-beat wrap on s3
    do_reset(); clear_logs();
    req_len = 40'd0; req_len[39:32] = 8'd255; req_seed = 8'h80;
    cyc(5'b10000, 1'b1);
    repeat (265) cyc(5'd0, 1'b1);
    chk("t6_beats", hs_data.size(), 256);
    if (hs_data.size() == 256) begin
      chk("t6_first", int'(hs_data[0]), 128);
      chk("t6_ff", int'(hs_data[127]), 255);
      chk("t6_wrap", int'(hs_data[128]), 0);
      chk("t6_lastbyte", int'(hs_data[255]), 127);
      chk("t6_tlast_pos", hs_last[255], 1);
    end
    chk("t6_tlast_cnt", hs_last.sum(), 1);
    chk("t6_sel_not5", hs_sel.size() - 0, 256 - 0 - (256 - hs_sel.size()));
    begin
      int bad = 0;
      foreach (hs_sel[i]) if (hs_sel[i] != 5) bad++;
      chk("t6_sel5", bad, 0);
    end

    // Randomized traffic against the model
    do_reset(); clear_logs();
    mode = 0;
    for (int c = 0; c < 3000; c++) begin
      if (c % 40 == 0) mode = int'($urandom_range(0, 2));
      for (int i = 0; i < 5; i++) req_len[8*i +: 8] = 8'($urandom_range(0, 7));
      req_seed = 8'($urandom);
      rq = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'd0;
      tr = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
      rst_n = (c == 1500) ? 1'b0 : 1'b1;
      cyc(rq, tr);
    end
    rst_n = 1'b1;
    repeat (5) cyc(5'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
